// File: rtl/bcd_display_scheduler_if.sv
// Value handshake between the game counter logic and the display scheduler.
interface bcd_display_scheduler_if #(
    parameter int WIDTH = 10
);
    logic             value_valid;
    logic [WIDTH-1:0] value;
    logic             value_ready;
    logic             busy;

    modport master (
        output value_valid,
        output value,
        input  value_ready,
        input  busy
    );

    modport slave (
        input  value_valid,
        input  value,
        output value_ready,
        output busy
    );
endinterface

// File: rtl/bcd_display_scheduler.sv
// Binary-to-BCD conversion (shift-add-3) and 4-digit seven-segment scan.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_BLANK_EN.
module bcd_display_scheduler #(
    parameter int WIDTH        = 10,
    parameter int REFRESH_BITS = 17
) (
    input  logic                    clock,
    input  logic                    reset,
    bcd_display_scheduler_if.slave  bus,
    output logic [3:0]              anode_signals,
    output logic [6:0]              display_out
);
    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

    state_t                  state;
    state_t                  next_state;
    logic                    handshake;
    logic [WIDTH-1:0]        shift_reg;
    logic [15:0]             bcd;
    logic [15:0]             bcd_adj;
    logic [3:0]              iter;
    logic [15:0]             digits;
    logic [REFRESH_BITS-1:0] refresh_counter;
    logic [1:0]              sel;
    logic [3:0]              anode_next;
    logic [3:0]              digit_sel;
    logic                    blank;
    logic [6:0]              seg_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        bus.value_ready = 1'b0;
        bus.busy        = 1'b1;
        handshake       = 1'b0;
        case (state)
            IDLE: begin
                bus.value_ready = 1'b1;
                bus.busy        = 1'b0;
                handshake       = bus.value_valid;
                if (bus.value_valid) begin
                    next_state = CONVERT;
                end
            end
            CONVERT: begin
                if (iter == LAST_ITER) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bcd       <= '0;
            iter      <= '0;
            digits    <= '0;
        end else begin
            if (handshake) begin
                shift_reg <= bus.value;
                bcd       <= '0;
                iter      <= '0;
            end else if (state == CONVERT) begin
                bcd       <= {bcd_adj[14:0], shift_reg[WIDTH-1]};
                shift_reg <= shift_reg << 1;
                iter      <= iter + 4'd1;
            end else if (state == UPDATE) begin
                digits <= bcd;
            end
        end
    end

    assign sel = refresh_counter[REFRESH_BITS-1 -: 2];

    always_comb begin
        anode_next = 4'b1111;
        digit_sel  = 4'd0;
        blank      = 1'b0;
        case (sel)
            2'd0: begin anode_next = 4'b0111; digit_sel = digits[15:12]; end
            2'd1: begin anode_next = 4'b1011; digit_sel = digits[11:8];  end
            2'd2: begin anode_next = 4'b1101; digit_sel = digits[7:4];   end
            default: begin anode_next = 4'b1110; digit_sel = digits[3:0]; end
        endcase
`ifdef BCD_LEADING_BLANK_EN
        // A digit is blanked only if it and every digit to its left are zero.
        case (sel)
            2'd0:    blank = (digits[15:12] == 4'd0);
            2'd1:    blank = (digits[15:8] == 8'd0);
            2'd2:    blank = (digits[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        seg_next = blank ? 7'b1111111 : seg7(digit_sel);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_counter <= '0;
            anode_signals   <= 4'b1111;
            display_out     <= 7'b1111111;
        end else begin
            refresh_counter <= refresh_counter + 1'b1;
            anode_signals   <= anode_next;
            display_out     <= seg_next;
        end
    end
endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed-vector bench for bcd_display_scheduler; short scan counter keeps frames to 16 cycles.
module tb_bcd_display_scheduler;
    localparam int WIDTH = 10;
    localparam int RB    = 4;
    localparam int FRAME = 1 << RB;

    logic       clock;
    logic       reset;
    logic [3:0] anode_signals;
    logic [6:0] display_out;
    int         vectors;
    int         miscompares;
    int         cyc;
    logic [6:0] frame_slots [4];

    bcd_display_scheduler_if #(.WIDTH(WIDTH)) bus_if ();

    bcd_display_scheduler #(
        .WIDTH(WIDTH),
        .REFRESH_BITS(RB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus_if),
        .anode_signals(anode_signals),
        .display_out(display_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Slot 0 = thousands ... slot 3 = ones.
    function automatic logic [6:0] expectedSlot(input int val, input int pos);
        int d;
        case (pos)
            0: d = (val / 1000) % 10;
            1: d = (val / 100) % 10;
            2: d = (val / 10) % 10;
            default: d = val % 10;
        endcase
`ifdef BCD_LEADING_BLANK_EN
        if (pos == 0 && val < 1000) return 7'b1111111;
        if (pos == 1 && val < 100)  return 7'b1111111;
        if (pos == 2 && val < 10)   return 7'b1111111;
`endif
        return segOf(d);
    endfunction

    task automatic applyStimulus(input int val, output int low_cycles);
        int n;
        @(negedge clock);
        n = 0;
        while (!bus_if.value_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        bus_if.value       = WIDTH'(val);
        bus_if.value_valid = 1'b1;
        @(posedge clock);
        #1 bus_if.value_valid = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus_if.value_ready) break;
            low_cycles++;
        end
    endtask

    task automatic captureFrame();
        for (int i = 0; i < 4; i++) frame_slots[i] = 'x;
        @(negedge clock);
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clock);
            case (anode_signals)
                4'b0111: frame_slots[0] = display_out;
                4'b1011: frame_slots[1] = display_out;
                4'b1101: frame_slots[2] = display_out;
                4'b1110: frame_slots[3] = display_out;
                default: ;
            endcase
        end
    endtask

    task automatic checkFrame(input string tag, input int val);
        captureFrame();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_slot%0d", tag, i), 16'(frame_slots[i]), 16'(expectedSlot(val, i)));
        end
    endtask

    initial begin
        int low;
        int first_hs;
        int second_hs;
        int n;

        vectors            = 0;
        miscompares        = 0;
        cyc                = 0;
        reset              = 1'b0;
        bus_if.value_valid = 1'b0;
        bus_if.value       = '0;

        #12;
        checkOutput("rst_anode", 16'(anode_signals), 16'h000F);
        checkOutput("rst_display", 16'(display_out), 16'h007F);
        checkOutput("rst_ready", 16'(bus_if.value_ready), 16'h0001);
        checkOutput("rst_busy", 16'(bus_if.busy), 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        checkFrame("post_rst", 0);

        applyStimulus(937, low);
        checkOutput("v937_busy_cycles", 16'(low), 16'd11);
        checkFrame("v937", 937);
        checkOutput("v937_ones_hand", 16'(frame_slots[3]), 16'(7'b0001111));
        checkOutput("v937_hund_hand", 16'(frame_slots[1]), 16'(7'b0000100));

        applyStimulus(1023, low);
        checkOutput("v1023_busy_cycles", 16'(low), 16'd11);
        checkFrame("v1023", 1023);

        applyStimulus(0, low);
        checkFrame("v0", 0);

        // Back-to-back: valid held high, second value accepted at the earliest slot.
        @(negedge clock);
        bus_if.value       = WIDTH'(5);
        bus_if.value_valid = 1'b1;
        @(posedge clock);
        #1 first_hs = cyc;
        bus_if.value = WIDTH'(600);
        second_hs = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus_if.value_ready) begin
                second_hs = cyc + 1;
                break;
            end
        end
        checkOutput("b2b_spacing", 16'(second_hs - first_hs), 16'd12);
        @(posedge clock);
        #1 bus_if.value = WIDTH'(123);
        repeat (4) @(posedge clock);
        #1 bus_if.value_valid = 1'b0;
        n = 0;
        while (!bus_if.value_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkFrame("b2b_600", 600);

        // Abort a conversion with reset four cycles in.
        @(negedge clock);
        bus_if.value       = WIDTH'(512);
        bus_if.value_valid = 1'b1;
        @(posedge clock);
        #1 bus_if.value_valid = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_anode", 16'(anode_signals), 16'h000F);
        checkOutput("abort_display", 16'(display_out), 16'h007F);
        checkOutput("abort_ready", 16'(bus_if.value_ready), 16'h0001);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!bus_if.value_ready) low++;
        end
        checkOutput("abort_no_update", 16'(low), 16'd0);
        checkFrame("abort", 0);

        applyStimulus(42, low);
        checkFrame("v42", 42);
        checkOutput("v42_ones_hand", 16'(frame_slots[3]), 16'(7'b0010010));
        checkOutput("v42_tens_hand", 16'(frame_slots[2]), 16'(7'b1001100));
`ifdef BCD_LEADING_BLANK_EN
        checkOutput("v42_thou_hand", 16'(frame_slots[0]), 16'(7'b1111111));
`else
        checkOutput("v42_thou_hand", 16'(frame_slots[0]), 16'(7'b0000001));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_display_scheduler.md
# bcd_display_scheduler

Sequencing controller for the 4-digit seven-segment display. It accepts a binary score/count through a valid/ready handshake and converts it to four BCD digits with an iterative shift-add-3 engine. It then holds those digits and time-multiplexes them onto the shared anode and cathode lines. It sits between the game counter logic and the board's display pins, and replaces ad-hoc per-digit drive with one owner of the display resource.

## Interface
- `WIDTH`, 10: bit width of the input value; legal range 4..13, so the result always fits in 4 decimal digits.
- `REFRESH_BITS`, 17: width of the free-running scan counter; its top 2 bits select the active digit.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- `value_valid` input 1: source presents a new value.
- `value` input WIDTH: unsigned binary value to display.
- `value_ready` output 1: scheduler can accept a value (IDLE state).
- `busy` output 1: conversion in progress; equals `!value_ready`.
- `anode_signals` output 4: active-low digit enables, MSB = leftmost digit.
- `display_out` output 7: active-low segments {a,b,c,d,e,f,g}; "0" = 7'b0000001.

## Operation
- FSM states:
  - IDLE: `value_ready`=1.
  - CONVERT: WIDTH iterations.
  - UPDATE: load the display digits, then return to IDLE.
- Handshake occurs at a rising edge with `value_valid && value_ready`.
  - `value` is sampled into the shift register and BCD accumulator = 0.
  - State -> CONVERT, iteration counter = 0.
- CONVERT, each cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, shift} shifts left 1.
  - Counter increments; after iteration WIDTH-1 -> UPDATE.
- UPDATE: the 16-bit BCD result is copied into the display digit register (thousands, hundreds, tens, ones); state -> IDLE.
- `value_valid` while busy is ignored. The source holds `value` until the handshake; there is no queueing.
- Scan runs continuously and independently of the FSM. `sel` = `refresh_counter[REFRESH_BITS-1 -: 2]`:
  - 00: anode 4'b0111, thousands
  - 01: anode 4'b1011, hundreds
  - 10: anode 4'b1101, tens
  - 11: anode 4'b1110, ones
- Digit-to-segment decode covers 0-9; codes 10-15 drive blank (7'b1111111). These codes are unreachable in normal operation.
- `refresh_counter` wraps modulo 2^REFRESH_BITS with no gap.
- Reset values:
  - FSM = IDLE; `value_ready`=1, `busy`=0.
  - Digits = 0; `refresh_counter` = 0.
  - `anode_signals` = 4'b1111 (all off); `display_out` = 7'b1111111 (blank).
- Reset during CONVERT or UPDATE aborts the conversion. The partial result is discarded, digits = 0, and the state returns to IDLE.

## Timing
- Handshake edge E0; CONVERT iterations occupy edges E1..E_WIDTH.
- Digit register updates at edge E_(WIDTH+1): 11 cycles after E0 at the default WIDTH.
- `value_ready` is high after E_(WIDTH+1); the next handshake is possible at E_(WIDTH+2) at the earliest.
- Throughput: one value per WIDTH+2 cycles.
- `anode_signals` and `display_out` are registered and lag `sel` by one cycle.
- Each digit is active for 2^(REFRESH_BITS-2) cycles. A full frame is 2^REFRESH_BITS cycles.
- A digit update mid-frame takes effect on the next cycle's segment register. No frame alignment is required.

## Configuration
- `BCD_LEADING_BLANK_EN` defined:
  - Leading-zero digits (thousands, then hundreds, then tens) drive `display_out` = 7'b1111111 while their anode is still asserted.
  - The ones digit is always shown; value 0 displays as a single "0".
- `BCD_LEADING_BLANK_EN` undefined:
  - All four digits are always decoded, e.g. 42 displays "0042".

## Test plan
- Reset low mid-run -> `anode_signals`=4'b1111, `display_out`=7'b1111111, `value_ready`=1 immediately (asynchronous). After release, the scan shows "0000" (blank-ones-"0" with the macro).
- Handshake `value`=937 -> `value_ready` low for 11 cycles; digits become 0,9,3,7. The slot with anode 4'b1110 shows 7'b0001111; the slot with anode 4'b1011 shows 7'b0000100.
- `value`=1023 (maximum) -> digits 1,0,2,3; `value`=0 -> digits 0,0,0,0.
- `value_valid` held high with values 5 then 600 -> second accepted exactly 12 cycles after the first; `value` changes while busy are ignored; final display is "0600".
- Reset asserted 4 cycles into the conversion of 512 -> digits stay 0, FSM returns to IDLE, no later UPDATE occurs.
- With `BCD_LEADING_BLANK_EN`, `value`=42 -> thousands and hundreds slots 7'b1111111, tens 7'b1001100, ones 7'b0010010. Without the macro, the leading slots show 7'b0000001.
